// File: rtl/alu_result_ctrl_pkg.sv
// alu_pkg: shared types and constants for the ALU result controller.
//   - irq_state_e : interrupt acknowledge FSM states
//   - DEF_*       : default parameter values for alu_result_ctrl
//   - ALU_DW      : ALU data width
//   - ENTRY_W     : FIFO entry width (data, plus parity when ALU_RES_PARITY_EN)
// Optional macro: ALU_RES_PARITY_EN widens FIFO entries by one parity bit.
package alu_pkg;

  localparam int ALU_DW          = 8;
  localparam int DEF_DEPTH       = 8;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_CLR_TIMEOUT = 4;

`ifdef ALU_RES_PARITY_EN
  localparam int ENTRY_W = ALU_DW + 1;
`else
  localparam int ENTRY_W = ALU_DW;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    CLR  = 2'd2
  } irq_state_e;

  // Even parity: XOR of all data bits.
  function automatic logic even_parity(input logic [ALU_DW-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/alu_result_ctrl_if.sv
// alu_res_if: result handshake between the controller (master) and host (slave).
//   res_valid  master->slave  FIFO head valid
//   res_data   master->slave  FIFO head data
//   res_ready  slave->master  host accepts head
//   res_parity master->slave  head parity bit (only with ALU_RES_PARITY_EN)
interface alu_res_if;
  import alu_pkg::*;

  logic              res_valid;
  logic [ALU_DW-1:0] res_data;
  logic              res_ready;
`ifdef ALU_RES_PARITY_EN
  logic              res_parity;

  modport master (output res_valid, output res_data, output res_parity, input res_ready);
  modport slave  (input res_valid, input res_data, input res_parity, output res_ready);
`else
  modport master (output res_valid, output res_data, input res_ready);
  modport slave  (input res_valid, input res_data, output res_ready);
`endif

endinterface

// File: rtl/alu_result_ctrl_fifo.sv
// alu_sync_fifo: single-clock FIFO with sticky overflow on dropped pushes.
//   alu_clk, rst_n  clock, async active-low reset
//   push_i/push_data_i  write request and data
//   pop_i           read request (ignored when empty)
//   ovf_clr_i       clears overflow_o; a drop in the same cycle wins
//   head_data_o     head entry, zero when empty
//   full_o/empty_o  occupancy == DEPTH / occupancy == 0
//   overflow_o      sticky, set when a push is dropped
module alu_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         alu_clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  input  logic         ovf_clr_i,
  output logic [W-1:0] head_data_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;
  logic          do_push, do_pop, drop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

  // A pop on a full FIFO frees the slot the simultaneous push needs.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign drop    = push_i && full_o && !do_pop;

  always_ff @(posedge alu_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (drop)           ovf_q <= 1'b1;
      else if (ovf_clr_i) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge alu_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Storage is not reset; masking keeps the head at zero while empty.
  assign head_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign overflow_o  = ovf_q;

endmodule

// File: rtl/alu_result_ctrl.sv
// alu_result_ctrl: buffers ALU results and runs the ALU interrupt ack protocol.
//   alu_clk, rst_n  clock, async active-low reset
//   alu_enable      ALU enable; results appear on alu_out one cycle later
//   alu_out         registered ALU result
//   alu_irq         ALU interrupt level
//   res_if          result handshake (valid/data/ready, optional parity)
//   fifo_full/fifo_empty/overflow/ovf_clr  FIFO status and sticky drop flag
//   irq_pending     interrupt latched, awaiting irq_ack
//   irq_ack         host acknowledge pulse
//   alu_irq_clr     clear request back to the ALU
//   irq_clr_err     sticky, clear request timed out
//   irq_count       saturating count of latched interrupts
// Optional macro: ALU_RES_PARITY_EN adds an even-parity bit per entry (res_if.res_parity).
//
// IRQ FSM states:
//   IDLE | no interrupt outstanding; alu_irq latches a new event
//   PEND | event latched, waiting for irq_ack
//   CLR  | alu_irq_clr asserted, waiting for alu_irq to drop or timeout
module alu_result_ctrl
  import alu_pkg::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int CLR_TIMEOUT = DEF_CLR_TIMEOUT
) (
  input  logic              alu_clk,
  input  logic              rst_n,
  input  logic              alu_enable,
  input  logic [ALU_DW-1:0] alu_out,
  input  logic              alu_irq,
  alu_res_if.master         res_if,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic              irq_pending,
  input  logic              irq_ack,
  output logic              alu_irq_clr,
  output logic              irq_clr_err,
  output logic [CNT_W-1:0]  irq_count
);

  localparam int TMR_W = $clog2(CLR_TIMEOUT) + 1;

  logic               en_d_q;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic               pop;

  // alu_out lags alu_enable by one cycle, so capture keys off the delayed enable.
  always_ff @(posedge alu_clk or negedge rst_n) begin
    if (!rst_n) en_d_q <= 1'b0;
    else        en_d_q <= alu_enable;
  end

`ifdef ALU_RES_PARITY_EN
  assign push_entry        = {even_parity(alu_out), alu_out};
  assign res_if.res_parity = head_entry[ALU_DW];
`else
  assign push_entry = alu_out;
`endif

  assign res_if.res_valid = !fifo_empty;
  assign res_if.res_data  = head_entry[ALU_DW-1:0];
  assign pop              = res_if.res_valid && res_if.res_ready;

  alu_sync_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .alu_clk     (alu_clk),
    .rst_n       (rst_n),
    .push_i      (en_d_q),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .ovf_clr_i   (ovf_clr),
    .head_data_o (head_entry),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .overflow_o  (overflow)
  );

  irq_state_e       state_q;
  logic [TMR_W-1:0] timer_q;
  logic             pending_q, clr_q, err_q;
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge alu_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      pending_q <= 1'b0;
      clr_q     <= 1'b0;
      err_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (alu_irq) begin
            state_q   <= PEND;
            pending_q <= 1'b1;
            if (count_q != {CNT_W{1'b1}}) count_q <= count_q + CNT_W'(1);
          end
        end
        PEND: begin
          if (irq_ack) begin
            state_q   <= CLR;
            pending_q <= 1'b0;
            clr_q     <= 1'b1;
            timer_q   <= '0;
          end
        end
        CLR: begin
          if (!alu_irq) begin
            state_q <= IDLE;
            clr_q   <= 1'b0;
          end else if (timer_q == TMR_W'(CLR_TIMEOUT - 1)) begin
            // ALU never dropped the interrupt; give up and flag it.
            state_q <= IDLE;
            clr_q   <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        default: begin
          state_q   <= IDLE;
          pending_q <= 1'b0;
          clr_q     <= 1'b0;
        end
      endcase
    end
  end

  assign irq_pending = pending_q;
  assign alu_irq_clr = clr_q;
  assign irq_clr_err = err_q;
  assign irq_count   = count_q;

endmodule

// File: tb/tb_alu_result_ctrl.sv
// tb_alu_result_ctrl: directed stimulus for alu_result_ctrl, checked every cycle
// against a queue-based behavioural model plus hand-computed literal expectations.
// Honours ALU_RES_PARITY_EN when defined.
module tb_alu_result_ctrl;
  import alu_pkg::*;

  localparam int DEPTH       = 8;
  localparam int CNT_W       = 8;
  localparam int CLR_TIMEOUT = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             alu_clk    = 1'b0;
  logic             rst_n      = 1'b0;
  logic             alu_enable = 1'b0;
  logic [7:0]       alu_out    = 8'h00;
  logic             alu_irq    = 1'b0;
  logic             ovf_clr    = 1'b0;
  logic             irq_ack    = 1'b0;
  logic             fifo_full, fifo_empty, overflow;
  logic             irq_pending, alu_irq_clr, irq_clr_err;
  logic [CNT_W-1:0] irq_count;

  alu_res_if res_if ();

  alu_result_ctrl #(
    .DEPTH       (DEPTH),
    .CNT_W       (CNT_W),
    .CLR_TIMEOUT (CLR_TIMEOUT)
  ) dut (
    .alu_clk     (alu_clk),
    .rst_n       (rst_n),
    .alu_enable  (alu_enable),
    .alu_out     (alu_out),
    .alu_irq     (alu_irq),
    .res_if      (res_if),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr),
    .irq_pending (irq_pending),
    .irq_ack     (irq_ack),
    .alu_irq_clr (alu_irq_clr),
    .irq_clr_err (irq_clr_err),
    .irq_count   (irq_count)
  );

  always #5 alu_clk = ~alu_clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_q[$];
  logic       m_en_prev = 1'b0;
  logic       m_ovf     = 1'b0;
  logic       m_pend    = 1'b0;
  logic       m_clr     = 1'b0;
  logic       m_err     = 1'b0;
  int         m_cnt     = 0;
  int         m_held    = 0;   // cycles alu_irq_clr has been high so far

  always @(posedge alu_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_en_prev = 1'b0;
      m_ovf = 1'b0; m_pend = 1'b0; m_clr = 1'b0; m_err = 1'b0;
      m_cnt = 0; m_held = 0;
    end else begin
      bit dropped;
      dropped = 1'b0;
      if (m_q.size() != 0 && res_if.res_ready) void'(m_q.pop_front());
      if (m_en_prev) begin
        if (m_q.size() < DEPTH) m_q.push_back(alu_out);
        else dropped = 1'b1;
      end
      if (dropped)      m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      m_en_prev = alu_enable;

      if (m_clr) begin
        if (!alu_irq) m_clr = 1'b0;
        else if (m_held == CLR_TIMEOUT) begin
          m_clr = 1'b0;
          m_err = 1'b1;
        end else m_held++;
      end else if (m_pend) begin
        if (irq_ack) begin
          m_pend = 1'b0;
          m_clr  = 1'b1;
          m_held = 1;
        end
      end else if (alu_irq) begin
        m_pend = 1'b1;
        if (m_cnt < CNT_MAX) m_cnt++;
      end
    end
  end

  always @(negedge alu_clk) begin
    chk("res_valid",   res_if.res_valid, m_q.size() != 0);
    chk("res_data",    res_if.res_data,  (m_q.size() != 0) ? m_q[0] : 8'h00);
    chk("fifo_full",   fifo_full,        m_q.size() == DEPTH);
    chk("fifo_empty",  fifo_empty,       m_q.size() == 0);
    chk("overflow",    overflow,         m_ovf);
    chk("irq_pending", irq_pending,      m_pend);
    chk("alu_irq_clr", alu_irq_clr,      m_clr);
    chk("irq_clr_err", irq_clr_err,      m_err);
    chk("irq_count",   irq_count,        m_cnt);
`ifdef ALU_RES_PARITY_EN
    chk("res_parity",  res_if.res_parity, (m_q.size() != 0) ? ^m_q[0] : 1'b0);
`endif
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge alu_clk);
    #2;
  endtask

  initial begin
    int n;
    res_if.res_ready = 1'b0;

    // Reset with enable high and 0xAA on the bus.
    alu_enable = 1'b1;
    alu_out    = 8'hAA;
    tick(); tick();
    chk("rst_valid", res_if.res_valid, 1'b0);
    chk("rst_empty", fifo_empty, 1'b1);
    chk("rst_count", irq_count, 0);
    rst_n = 1'b1;
    tick();                       // en_d rises here, nothing pushed yet
    chk("first_no_push", res_if.res_valid, 1'b0);
    alu_enable = 1'b0;
    tick();                       // push of 0xAA
    chk("first_valid", res_if.res_valid, 1'b1);
    chk("first_data", res_if.res_data, 8'hAA);
    res_if.res_ready = 1'b1;
    tick();
    res_if.res_ready = 1'b0;
    chk("first_drained", fifo_empty, 1'b1);

    // Overflow: 10 results into an 8-deep FIFO, ovf_clr colliding with a drop.
    alu_enable = 1'b1; alu_out = 8'h00;
    tick();
    for (int i = 1; i <= 10; i++) begin
      alu_out    = 8'(i);
      alu_enable = (i < 10);
      ovf_clr    = (i == 10);
      tick();
      if (i == 8) begin
        chk("fill_full", fifo_full, 1'b1);
        chk("fill_no_ovf", overflow, 1'b0);
      end
      if (i == 9) chk("drop_ovf", overflow, 1'b1);
    end
    ovf_clr = 1'b0;
    chk("ovf_set_wins", overflow, 1'b1);
    alu_out = 8'h00;
    res_if.res_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain_order", res_if.res_data, i);
      tick();
    end
    res_if.res_ready = 1'b0;
    chk("drain_empty", fifo_empty, 1'b1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared", overflow, 1'b0);

    // Full FIFO with simultaneous push and pop.
    alu_enable = 1'b1;
    tick();
    for (int i = 1; i <= 14; i++) begin
      alu_out          = 8'(i);
      alu_enable       = (i < 14);
      res_if.res_ready = (i >= 9);
      tick();
      if (i >= 9) begin
        chk("pp_full", fifo_full, 1'b1);
        chk("pp_no_ovf", overflow, 1'b0);
        chk("pp_head", res_if.res_data, i - 7);
      end
    end
    res_if.res_ready = 1'b1;
    alu_out = 8'h00;
    for (int v = 7; v <= 14; v++) begin
      chk("pp_order", res_if.res_data, v);
      tick();
    end
    res_if.res_ready = 1'b0;
    chk("pp_empty", fifo_empty, 1'b1);

    // Interrupt acknowledged 3 cycles after it rises, ALU drops it promptly.
    alu_irq = 1'b1;
    tick();
    chk("irq_latched", irq_pending, 1'b1);
    chk("irq_count1", irq_count, 1);
    tick(); tick();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("ack_pend_low", irq_pending, 1'b0);
    chk("ack_clr_high", alu_irq_clr, 1'b1);
    tick();
    chk("clr_held", alu_irq_clr, 1'b1);
    alu_irq = 1'b0;
    tick();
    chk("clr_dropped", alu_irq_clr, 1'b0);
    chk("no_err", irq_clr_err, 1'b0);
    irq_ack = 1'b1;               // ack outside PEND is ignored
    tick();
    irq_ack = 1'b0;
    chk("stray_ack", alu_irq_clr, 1'b0);

    // Reset mid-operation with FIFO content and a latched interrupt.
    alu_enable = 1'b1; alu_out = 8'h55; alu_irq = 1'b1;
    tick(); tick(); tick();
    alu_enable = 1'b0; alu_irq = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("midrst_empty", fifo_empty, 1'b1);
    chk("midrst_pend", irq_pending, 1'b0);
    rst_n = 1'b1;
    tick();

    // Interrupt stuck high: clear times out, event re-latches.
    alu_irq = 1'b1;
    tick();
    chk("stuck_count1", irq_count, 1);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    n = 0;
    while (alu_irq_clr && n < 20) begin
      n++;
      tick();
    end
    chk("clr_cycles", n, CLR_TIMEOUT);
    chk("clr_err", irq_clr_err, 1'b1);
    tick();
    chk("relatch_pend", irq_pending, 1'b1);
    chk("relatch_count", irq_count, 2);
    alu_irq = 1'b0;
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    tick();
    chk("err_sticky", irq_clr_err, 1'b1);

`ifdef ALU_RES_PARITY_EN
    alu_enable = 1'b1;
    tick();
    alu_out = 8'h07;
    tick();
    alu_enable = 1'b0;
    alu_out = 8'h03;
    tick();
    chk("par_07", res_if.res_parity, 1'b1);
    res_if.res_ready = 1'b1;
    tick();
    chk("par_03", res_if.res_parity, 1'b0);
    tick();
    res_if.res_ready = 1'b0;
`endif

    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_result_ctrl.md
Name: alu_result_ctrl

Overview:
- Downstream stage of the ALU. Consumes the registered ALU result (alu_out) and the ALU interrupt (alu_irq).
- Buffers each result produced in an enabled cycle into a small FIFO, which the host drains through a valid/ready handshake.
- Runs the interrupt acknowledge protocol and drives alu_irq_clr back into the ALU.

Parameters:
- DEPTH, 8, FIFO entries; power of two, range 2..16.
- CNT_W, 8, width of the saturating interrupt event counter.
- CLR_TIMEOUT, 4, maximum cycles alu_irq_clr is held while waiting for alu_irq to drop.

Ports:
- alu_clk  in  1  clock, all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- alu_enable  in  1  same alu_enable driven to the ALU; marks a result-producing cycle.
- alu_out  in  8  registered ALU result.
- alu_irq  in  1  ALU interrupt, level.
- res_valid  out  1  FIFO head valid.
- res_data  out  8  FIFO head data.
- res_ready  in  1  host accepts head.
- fifo_full  out  1  occupancy == DEPTH.
- fifo_empty  out  1  occupancy == 0.
- overflow  out  1  sticky, result dropped.
- ovf_clr  in  1  clears overflow.
- irq_pending  out  1  interrupt latched, awaiting ack.
- irq_ack  in  1  host acknowledge, single-cycle pulse.
- alu_irq_clr  out  1  clear request to the ALU.
- irq_clr_err  out  1  sticky, clear timed out.
- irq_count  out  CNT_W  saturating count of latched interrupts.

Behaviour:
Reset:
- All outputs 0, except fifo_empty=1.
- FIFO pointers 0, FSM in IDLE, en_d=0.
- Reset mid-operation discards FIFO contents and any in-flight clear.

Capture:
- en_d is alu_enable registered by one cycle (alu_out is one cycle behind alu_enable).
- Push alu_out on every edge where en_d=1.
- Latency: alu_enable high at edge N gives a result in alu_out after N; it is pushed at N+1 and res_valid is high after N+1 if the FIFO was empty.
- No bypass.

FIFO:
- res_data is always the head entry.
- Pop when res_valid && res_ready.
- Push and pop in the same cycle:
  - Not full and not empty: both occur, occupancy unchanged.
  - Full: pop frees a slot, push is accepted, no overflow.
  - Empty: only the push takes effect.
- Push when full without pop: data dropped, overflow set.
- ovf_clr clears overflow. If ovf_clr and a new drop occur in the same cycle, set wins.
- Pointers wrap modulo DEPTH. An occupancy counter of width log2(DEPTH)+1 drives full/empty.

IRQ FSM (IDLE, PEND, CLR):
- IDLE:
  - alu_irq=1 -> PEND.
  - irq_pending<=1.
  - irq_count increments, saturating at 2^CNT_W-1.
- PEND:
  - irq_pending=1.
  - irq_ack=1 -> CLR.
  - irq_pending<=0, alu_irq_clr<=1, timer<=0.
- CLR:
  - alu_irq_clr held at 1.
  - alu_irq=0 at an edge -> IDLE, alu_irq_clr<=0.
  - Otherwise timer increments. When the timer reaches CLR_TIMEOUT-1 -> IDLE, alu_irq_clr<=0, irq_clr_err<=1.
- irq_ack outside PEND is ignored.
- alu_irq still high on the cycle after returning to IDLE re-latches as a new event.
- irq_clr_err clears only on reset.
- FIFO and FSM operate independently; capture continues during CLR, so the cleared 0x00 result is buffered like any other.

Optional Feature:
- ALU_RES_PARITY_EN defined:
  - FIFO entries are 9 bits: data plus even parity (XOR of the 8 data bits), computed at push.
  - Extra output res_parity (1 bit, out) reflects the head parity bit; reset 0.
- Not defined: 8-bit entries, no res_parity port.

Decomposition:
- Package alu_pkg holds:
  - IRQ FSM state enum (IDLE=2'd0, PEND=2'd1, CLR=2'd2).
  - Default DEPTH, CNT_W and CLR_TIMEOUT constants.
  - ALU data width constant 8.
- Sub-module alu_sync_fifo:
  - Parameterised width and depth.
  - push/pop/full/empty/overflow-drop logic.
- alu_result_ctrl instantiates alu_sync_fifo and holds en_d, the IRQ FSM, the timer and the counter.

Test Plan:
- Reset with alu_enable=1 and alu_out=0xAA -> all outputs 0, fifo_empty=1. After release, the first push occurs one edge after en_d rises; res_valid=1 with res_data=0xAA.
- res_ready=0, enable held 10 cycles with alu_out 0x01..0x0A -> fifo_full after 8 pushes, overflow=1, 0x09 and 0x0A dropped. Draining returns 0x01..0x08 in order, then fifo_empty=1.
- FIFO full with res_ready=1 and enable held -> occupancy stays 8, overflow stays 0, output order preserved.
- alu_irq rises and irq_ack pulses 3 cycles later -> irq_pending=1 then 0, alu_irq_clr=1 until the edge after alu_irq falls, irq_count=1.
- alu_irq stuck at 1 after irq_ack -> alu_irq_clr high exactly 4 cycles, irq_clr_err=1, FSM re-latches PEND, irq_count=2.
- ALU_RES_PARITY_EN defined, push 0x07 then 0x03 -> res_parity=1 then 0.
